// File: rtl/if_prefetch_stage.sv
`timescale 1ns/1ps
// if_prefetch_stage
//   Instruction-fetch stage. It fetches words from instruction memory over a
//   req/ack handshake and buffers them in a DEPTH-entry prefetch queue. The
//   queue head is presented to decode as Instruction/PC. The head is held
//   while decode asserts freeze. A taken branch flushes the queue and
//   redirects the fetch PC.
//
// Optional feature: define IF_PERF_CNT_EN to add the stall_cnt/flush_cnt
//   performance counters. Both counters saturate.
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   freeze            decode stall; the head entry is held
//   branch_taken      redirect request; takes priority over everything else
//   branch_addr       redirect target (word aligned)
//   imem_req/addr     fetch request; held with a stable address until imem_ack
//   imem_ack/rdata    memory accepted the request; rdata is valid this cycle
//   Instruction, PC   head word and head address + 4 (NOP_INST / 0 when empty)
//   inst_valid        queue not empty
//   stall_cnt         cycles with freeze & inst_valid (IF_PERF_CNT_EN only)
//   flush_cnt         branch_taken cycles (IF_PERF_CNT_EN only)
module if_prefetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        inst_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc, fetch_pc_nxt;
  logic [31:0]     disc_addr;
  entry_t          q_mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            push, pop;

  // Queue control. A branch suppresses both push and pop: the data in
  // flight belongs to the wrong path and the head is about to be flushed.
  assign push = (state == REQ) & imem_ack & ~branch_taken;
  assign pop  = inst_valid & ~freeze & ~branch_taken;

  always_comb begin
    count_nxt = count;
    if (branch_taken)
      count_nxt = '0;
    else
      count_nxt = count + CW'(push) - CW'(pop);
  end

  // Fetch FSM: at most one request outstanding. Entry into REQ is gated on
  // the post-update occupancy, so the outstanding request always owns a slot.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (count_nxt < CW'(DEPTH)) state_nxt = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (!branch_taken) fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
        end else if (branch_taken) begin
          // Request cannot be withdrawn; wait for its ack and drop the data.
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (branch_taken) fetch_pc_nxt = branch_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // fetch_pc may be retargeted while a discarded request is still pending,
  // so the pending address is kept separately to hold imem_addr stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      disc_addr <= RESET_PC;
    else if (state == REQ && state_nxt == DISCARD)
      disc_addr <= fetch_pc;
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = (state == DISCARD) ? disc_addr : fetch_pc;

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{addr: imem_addr, word: imem_rdata};
  end

  assign head        = q_mem[rd_ptr];
  assign inst_valid  = (count != '0);
  assign Instruction = inst_valid ? head.word : NOP_INST;
  assign PC          = inst_valid ? head.addr + 32'd4 : 32'd0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && inst_valid && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
`timescale 1ns/1ps
// Bench for if_prefetch_stage (DEPTH=4). The memory model acks in the same
// cycle as the request, with rdata = address, unless held or overridden.
// The stimulus loads the expected address stream into a scoreboard queue;
// a negedge monitor checks the head against the queue and pops on consume.
module tb_if_prefetch_stage;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instruction, PC;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  logic        mem_hold = 1'b0;
  logic        force_en = 1'b0;
  logic [31:0] force_data = 32'd0;
  logic        seen_dead = 1'b0;
  logic [31:0] sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign imem_ack   = imem_req & ~mem_hold;
  assign imem_rdata = force_en ? force_data : imem_addr;

  if_prefetch_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PC(PC), .inst_valid(inst_valid)
`ifdef IF_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Expected consume order after a (re)start at base.
  task automatic load(input logic [31:0] base);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(base + 32'(4 * i));
  endtask

  // Monitor: head must match the scoreboard front whenever valid; it pops
  // when decode consumes. Branch cycles are skipped (the queue was reloaded).
  always @(negedge clk) begin
    if (!rst && inst_valid && Instruction == 32'h0000_DEAD) seen_dead = 1'b1;
    if (!rst && !branch_taken) begin
      if (inst_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got word %08h want none", Instruction);
        end else begin
          chk("head_inst", Instruction, sb_q[0]);
          chk("head_pc", PC, sb_q[0] + 32'd4);
          if (!freeze) void'(sb_q.pop_front());
        end
      end else begin
        chk("empty_inst", Instruction, NOP);
        chk("empty_pc", PC, 32'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    load(32'h0);
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", Instruction, NOP);
    chk("rst_pc", PC, 0);

    // 1: zero-wait stream from RESET_PC
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);                      // still IDLE
    @(negedge clk);
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid_early", inst_valid, 0);
    @(negedge clk);
    chk("t1_valid", inst_valid, 1);
    repeat (6) @(negedge clk);

    // 2: freeze fills the queue, then release without loss or duplication
    @(posedge clk); #1 freeze = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t2_req_full", imem_req, 0);
    chk("t2_valid", inst_valid, 1);
    @(posedge clk); #1 freeze = 1'b0;
    repeat (6) @(negedge clk);

    // 3: branch while the refilled queue holds 3 entries
    @(posedge clk); #1 branch_taken = 1'b1; branch_addr = 32'h100; load(32'h100);
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t3_valid", inst_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("t3_inst", Instruction, 32'h100);
    chk("t3_pc", PC, 32'h104);
    repeat (3) @(negedge clk);

    // 4: branch during a pending request to 0x10; its late ack is dropped
    @(posedge clk); #1 freeze = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_idle", imem_req, 0);
    @(posedge clk); #1 freeze = 1'b0; mem_hold = 1'b1;
    branch_taken = 1'b1; branch_addr = 32'h10; load(32'h10);
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h10);
    @(posedge clk); #1 branch_taken = 1'b1; branch_addr = 32'h200; load(32'h200);
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t4_disc_req", imem_req, 1);
    chk("t4_disc_addr", imem_addr, 32'h10);
    chk("t4_disc_valid", inst_valid, 0);
    @(posedge clk);
    @(posedge clk); #1 force_data = 32'h0000_DEAD; force_en = 1'b1; mem_hold = 1'b0;
    @(posedge clk); #1 force_en = 1'b0;
    @(negedge clk);
    chk("t4_redirect", imem_addr, 32'h200);
    chk("t4_valid", inst_valid, 0);
    @(negedge clk);
    chk("t4_inst", Instruction, 32'h200);
    repeat (3) @(negedge clk);

    // 5: reset asserted with a request pending and a valid head
    @(posedge clk); #1 freeze = 1'b1; mem_hold = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t5_req", imem_req, 0);
    chk("t5_valid", inst_valid, 0);
    chk("t5_inst", Instruction, NOP);
    chk("t5_pc", PC, 0);
    load(32'h0);
    @(posedge clk); #1 freeze = 1'b0;
    @(posedge clk); #1 rst = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_first_addr", imem_addr, 32'h0);
    chk("t5_first_req", imem_req, 1);
    repeat (3) @(negedge clk);

`ifdef IF_PERF_CNT_EN
    // 6: 5 frozen valid cycles then 2 branch cycles
    chk("t6_stall_rst", stall_cnt, 0);
    chk("t6_flush_rst", flush_cnt, 0);
    @(posedge clk); #1 freeze = 1'b1;
    repeat (5) @(posedge clk);
    #1 freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h300; load(32'h300);
    @(posedge clk); #1 branch_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1 branch_taken = 1'b1; branch_addr = 32'h400; load(32'h400);
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("t6_stall", stall_cnt, 5);
    chk("t6_flush", flush_cnt, 2);
`endif

    repeat (6) @(negedge clk);
    chk("no_dead_word", seen_dead, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
